// File: rtl/tlb_pkg.sv
// tlb_pkg: shared definitions for the CP0 TLB register block.
//   - TLB geometry (TLB_LINE entries, TLB_WIDTH index bits)
//   - TLB operation encodings driven on tlb_typeM
//   - CP0 register numbers and per-register writable-bit masks
//   - operation sequencer state enum
package tlb_pkg;

  localparam int TLB_LINE  = 32;
  localparam int TLB_WIDTH = 5;

  // TLB operation strobe encodings
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_TLBP  = 3'd1;
  localparam logic [2:0] OP_TLBR  = 3'd2;
  localparam logic [2:0] OP_TLBWI = 3'd3;
  localparam logic [2:0] OP_TLBWR = 3'd4;

  // CP0 register numbers (all live at select 0)
  localparam logic [4:0] REG_INDEX    = 5'd0;
  localparam logic [4:0] REG_RANDOM   = 5'd1;
  localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
  localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
  localparam logic [4:0] REG_PAGEMASK = 5'd5;
  localparam logic [4:0] REG_WIRED    = 5'd6;
  localparam logic [4:0] REG_ENTRYHI  = 5'd10;

  // Bits that may hold a non-zero value; everything else reads 0.
  localparam logic [31:0] INDEX_MASK       = 32'h8000_001F; // P bit + index
  localparam logic [31:0] INDEX_MTC0_MASK  = 32'h0000_001F; // P is hardware-only
  localparam logic [31:0] ENTRYLO_MASK     = 32'h3FFF_FFFF;
  localparam logic [31:0] PAGEMASK_MASK    = 32'h1FFF_E000;
  localparam logic [31:0] ENTRYHI_MASK     = 32'hFFFF_E0FF; // VPN2 + ASID
  localparam logic [31:0] ENTRYHI_VPN_MASK = 32'hFFFF_E000;
  localparam logic [31:0] ENTRYHI_ASID     = 32'h0000_00FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } tlb_state_e;

endpackage

// File: rtl/cp0_random_counter.sv
// cp0_random_counter: the Wired register and the free-running Random counter.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wired_we/wdata      write to Wired; also restarts Random at TLB_LINE-1
//   freeze              hold Random (asserted while a TLB op is being issued)
//   wired_o, random_o   current register values
// Random counts down every cycle and reloads TLB_LINE-1 after reaching Wired.
// When wired_we is tied low the Wired flops stay 0, so Random wraps at 0.
module cp0_random_counter
  import tlb_pkg::*;
#(
  parameter int TLB_LINE  = tlb_pkg::TLB_LINE,
  parameter int TLB_WIDTH = tlb_pkg::TLB_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wired_we,
  input  logic [TLB_WIDTH-1:0] wired_wdata,
  input  logic                 freeze,
  output logic [TLB_WIDTH-1:0] wired_o,
  output logic [TLB_WIDTH-1:0] random_o
);

  localparam logic [TLB_WIDTH-1:0] RANDOM_TOP = TLB_WIDTH'(TLB_LINE - 1);

  logic [TLB_WIDTH-1:0] wired_q, wired_d;
  logic [TLB_WIDTH-1:0] random_q, random_d;

  always_comb begin
    wired_d  = wired_q;
    random_d = random_q;
    if (wired_we) begin
      wired_d  = wired_wdata;
      random_d = RANDOM_TOP;
    end else if (!freeze) begin
      // "<=" rather than "==" also pins Random at the top when
      // Wired >= TLB_LINE-1, since Random never exceeds the top.
      if (random_q <= wired_q) begin
        random_d = RANDOM_TOP;
      end else begin
        random_d = random_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wired_q  <= '0;
      random_q <= RANDOM_TOP;
    end else begin
      wired_q  <= wired_d;
      random_q <= random_d;
    end
  end

  assign wired_o  = wired_q;
  assign random_o = random_q;

endmodule

// File: rtl/cp0_tlb_regs.sv
// cp0_tlb_regs: CP0 TLB register block and TLB operation sequencer.
// Optional feature macro: CP0_TLB_WIRED_EN (Wired register writable; Random
// wraps at Wired). Without it Wired reads 0 and Random wraps at 0.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   mtc0_en/addr/sel/data          CP0 register write
//   mfc0_addr/sel -> mfc0_data     combinational CP0 register read
//   op_valid/op -> op_ready        TLB instruction request handshake
//   op_done                        one-cycle completion pulse
//   exc_tlb/exc_vaddr              TLB exception commit, loads EntryHi VPN2
//   tlb_typeM                      one-cycle op strobe to the TLB
//   *_o                            register values driven to the TLB
//   *_i                            TLBP/TLBR results from the TLB
module cp0_tlb_regs
  import tlb_pkg::*;
#(
  parameter int TLB_LINE  = tlb_pkg::TLB_LINE,
  parameter int TLB_WIDTH = tlb_pkg::TLB_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_en,
  input  logic [4:0]  mtc0_addr,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  input  logic [2:0]  mfc0_sel,
  output logic [31:0] mfc0_data,
  input  logic        op_valid,
  input  logic [2:0]  op,
  output logic        op_ready,
  output logic        op_done,
  input  logic        exc_tlb,
  input  logic [31:0] exc_vaddr,
  output logic [2:0]  tlb_typeM,
  output logic [31:0] EntryHi_o,
  output logic [31:0] PageMask_o,
  output logic [31:0] EntryLo0_o,
  output logic [31:0] EntryLo1_o,
  output logic [31:0] Index_o,
  output logic [31:0] Random_o,
  input  logic [31:0] EntryHi_i,
  input  logic [31:0] PageMask_i,
  input  logic [31:0] EntryLo0_i,
  input  logic [31:0] EntryLo1_i,
  input  logic [31:0] Index_i
);

  tlb_state_e state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] index_q, index_d;
  logic [31:0] entrylo0_q, entrylo0_d;
  logic [31:0] entrylo1_q, entrylo1_d;
  logic [31:0] pagemask_q, pagemask_d;
  logic [31:0] entryhi_q, entryhi_d;

  logic                 wr_sel0;
  logic                 wired_we;
  logic [TLB_WIDTH-1:0] wired_val;
  logic [TLB_WIDTH-1:0] random_val;
  logic [31:0]          wired_word;

  assign wr_sel0 = mtc0_en && (mtc0_sel == 3'd0);

`ifdef CP0_TLB_WIRED_EN
  assign wired_we = wr_sel0 && (mtc0_addr == REG_WIRED);
`else
  // Wired is never written, so it stays 0 and Random wraps at 0.
  assign wired_we = 1'b0;
`endif

  cp0_random_counter #(
    .TLB_LINE  (TLB_LINE),
    .TLB_WIDTH (TLB_WIDTH)
  ) u_random (
    .clk         (clk),
    .rst         (rst),
    .wired_we    (wired_we),
    .wired_wdata (mtc0_data[TLB_WIDTH-1:0]),
    .freeze      (state_q == ST_ISSUE),
    .wired_o     (wired_val),
    .random_o    (random_val)
  );

  assign wired_word = {{(32-TLB_WIDTH){1'b0}}, wired_val};

  // Sequencer: IDLE accepts, ISSUE strobes the TLB, DONE reports completion.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d    = op;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Register updates. Assignments are ordered lowest priority first
  // (mtc0, then TLB capture, then exception) so the later one wins, and
  // only for the register actually in conflict.
  always_comb begin
    index_d    = index_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    pagemask_d = pagemask_q;
    entryhi_d  = entryhi_q;

    if (wr_sel0) begin
      case (mtc0_addr)
        REG_INDEX:    index_d    = (index_q & ~INDEX_MTC0_MASK) | (mtc0_data & INDEX_MTC0_MASK);
        REG_ENTRYLO0: entrylo0_d = mtc0_data & ENTRYLO_MASK;
        REG_ENTRYLO1: entrylo1_d = mtc0_data & ENTRYLO_MASK;
        REG_PAGEMASK: pagemask_d = mtc0_data & PAGEMASK_MASK;
        REG_ENTRYHI:  entryhi_d  = mtc0_data & ENTRYHI_MASK;
        default: ;
      endcase
    end

    if (state_q == ST_ISSUE) begin
      if (op_q == OP_TLBP) begin
        index_d = Index_i & INDEX_MASK;
      end else if (op_q == OP_TLBR) begin
        entryhi_d  = EntryHi_i  & ENTRYHI_MASK;
        pagemask_d = PageMask_i & PAGEMASK_MASK;
        entrylo0_d = EntryLo0_i & ENTRYLO_MASK;
        entrylo1_d = EntryLo1_i & ENTRYLO_MASK;
      end
    end

    // Exception keeps the pre-edge ASID, discarding any same-edge write.
    if (exc_tlb) begin
      entryhi_d = (exc_vaddr & ENTRYHI_VPN_MASK) | (entryhi_q & ENTRYHI_ASID);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NONE;
      index_q    <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      pagemask_q <= '0;
      entryhi_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      index_q    <= index_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
      pagemask_q <= pagemask_d;
      entryhi_q  <= entryhi_d;
    end
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign op_done   = (state_q == ST_DONE);
  assign tlb_typeM = (state_q == ST_ISSUE) ? op_q : OP_NONE;

  assign Index_o    = index_q;
  assign Random_o   = {{(32-TLB_WIDTH){1'b0}}, random_val};
  assign EntryLo0_o = entrylo0_q;
  assign EntryLo1_o = entrylo1_q;
  assign PageMask_o = pagemask_q;
  assign EntryHi_o  = entryhi_q;

  always_comb begin
    mfc0_data = 32'h0;
    if (mfc0_sel == 3'd0) begin
      case (mfc0_addr)
        REG_INDEX:    mfc0_data = index_q;
        REG_RANDOM:   mfc0_data = Random_o;
        REG_ENTRYLO0: mfc0_data = entrylo0_q;
        REG_ENTRYLO1: mfc0_data = entrylo1_q;
        REG_PAGEMASK: mfc0_data = pagemask_q;
        REG_WIRED:    mfc0_data = wired_word;
        REG_ENTRYHI:  mfc0_data = entryhi_q;
        default:      mfc0_data = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// tb_cp0_tlb_regs: directed self-checking bench for cp0_tlb_regs.
// Builds with or without CP0_TLB_WIRED_EN; the Random/Wired scenario adapts.
module tb_cp0_tlb_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mtc0_en = 1'b0;
  logic [4:0]  mtc0_addr = '0;
  logic [2:0]  mtc0_sel = '0;
  logic [31:0] mtc0_data = '0;
  logic [4:0]  mfc0_addr = '0;
  logic [2:0]  mfc0_sel = '0;
  logic [31:0] mfc0_data;
  logic        op_valid = 1'b0;
  logic [2:0]  op = '0;
  logic        op_ready, op_done;
  logic        exc_tlb = 1'b0;
  logic [31:0] exc_vaddr = '0;
  logic [2:0]  tlb_typeM;
  logic [31:0] EntryHi_o, PageMask_o, EntryLo0_o, EntryLo1_o, Index_o, Random_o;
  logic [31:0] EntryHi_i = '0, PageMask_i = '0, EntryLo0_i = '0, EntryLo1_i = '0, Index_i = '0;

  int errors = 0;
  int checks = 0;

  cp0_tlb_regs dut (
    .clk(clk), .rst(rst),
    .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_sel(mtc0_sel), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_sel(mfc0_sel), .mfc0_data(mfc0_data),
    .op_valid(op_valid), .op(op), .op_ready(op_ready), .op_done(op_done),
    .exc_tlb(exc_tlb), .exc_vaddr(exc_vaddr), .tlb_typeM(tlb_typeM),
    .EntryHi_o(EntryHi_o), .PageMask_o(PageMask_o), .EntryLo0_o(EntryLo0_o),
    .EntryLo1_o(EntryLo1_o), .Index_o(Index_o), .Random_o(Random_o),
    .EntryHi_i(EntryHi_i), .PageMask_i(PageMask_i), .EntryLo0_i(EntryLo0_i),
    .EntryLo1_i(EntryLo1_i), .Index_i(Index_i)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_en = 1'b1; mtc0_addr = a; mtc0_sel = 3'd0; mtc0_data = d;
    tick;
    mtc0_en = 1'b0;
    $display("mtc0 reg=%0d data=%h", a, d);
  endtask

  task test_reset;
    repeat (3) tick;
    rst = 1'b0;
    mfc0_addr = 5'd10;
    #1;
    checks++; if (Random_o !== 32'd31) begin errors++; $display("FAIL reset_random got=%h exp=%h", Random_o, 32'd31); end
    checks++; if (Index_o !== 32'd0) begin errors++; $display("FAIL reset_index got=%h exp=%h", Index_o, 32'd0); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got=%b exp=1", op_ready); end
    checks++; if (tlb_typeM !== 3'd0) begin errors++; $display("FAIL reset_typeM got=%0d exp=0", tlb_typeM); end
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL reset_op_done got=%b exp=0", op_done); end
    checks++; if (mfc0_data !== 32'h0) begin errors++; $display("FAIL reset_mfc0_entryhi got=%h exp=%h", mfc0_data, 32'h0); end
    $display("reset released: Random=%0d Index=%h", Random_o, Index_o);
  endtask

  task test_random;
    logic [31:0] r0;
    logic [31:0] exp;
    int          waited;
    // align to just after an edge so the write lands on the next one
    tick;
    r0 = Random_o;
    do_mtc0(5'd6, 32'd4);
    mfc0_addr = 5'd6;
    #1;
`ifdef CP0_TLB_WIRED_EN
    checks++; if (mfc0_data !== 32'd4) begin errors++; $display("FAIL wired_read got=%h exp=%h", mfc0_data, 32'd4); end
    for (int k = 0; k <= 28; k++) begin
      exp = (k <= 27) ? 32'(31 - k) : 32'd31;
      checks++; if (Random_o !== exp) begin errors++; $display("FAIL random_seq k=%0d got=%0d exp=%0d", k, Random_o, exp); end
      tick;
    end
    $display("random sequence with wired=4 walked 31..4,31");
`else
    checks++; if (mfc0_data !== 32'd0) begin errors++; $display("FAIL wired_read got=%h exp=%h", mfc0_data, 32'd0); end
    exp = (r0 == 32'd0) ? 32'd31 : r0 - 32'd1;
    checks++; if (Random_o !== exp) begin errors++; $display("FAIL random_no_reload got=%0d exp=%0d", Random_o, exp); end
    waited = 0;
    while (Random_o !== 32'd0 && waited < 40) begin
      tick;
      waited++;
    end
    checks++; if (Random_o !== 32'd0) begin errors++; $display("FAIL random_reach_zero got=%0d exp=0 after %0d cycles", Random_o, waited); end
    tick;
    checks++; if (Random_o !== 32'd31) begin errors++; $display("FAIL random_wrap got=%0d exp=31", Random_o); end
    tick;
    checks++; if (Random_o !== 32'd30) begin errors++; $display("FAIL random_after_wrap got=%0d exp=30", Random_o); end
    $display("random wrapped 0 -> 31 with wired disabled");
`endif
  endtask

  task test_tlbp;
    logic [31:0] r_issue;
    // first probe: hit at index 7
    Index_i = 32'h0000_0007; op = 3'd1; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    r_issue = Random_o;
    checks++; if (tlb_typeM !== 3'd1) begin errors++; $display("FAIL tlbp_typeM_issue got=%0d exp=1", tlb_typeM); end
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL tlbp_ready_issue got=%b exp=0", op_ready); end
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL tlbp_done_issue got=%b exp=0", op_done); end
    tick;
    checks++; if (tlb_typeM !== 3'd0) begin errors++; $display("FAIL tlbp_typeM_done got=%0d exp=0", tlb_typeM); end
    checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL tlbp_done got=%b exp=1", op_done); end
    checks++; if (Index_o !== 32'h0000_0007) begin errors++; $display("FAIL tlbp_index got=%h exp=%h", Index_o, 32'h7); end
    checks++; if (Random_o !== r_issue) begin errors++; $display("FAIL random_frozen got=%0d exp=%0d", Random_o, r_issue); end
    tick;
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL tlbp_done_pulse got=%b exp=0", op_done); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL tlbp_ready_back got=%b exp=1", op_ready); end
    $display("tlbp Index_i=%h -> Index=%h", Index_i, Index_o);
    // second probe: miss (P bit set)
    Index_i = 32'h8000_0000; op = 3'd1; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    tick;
    mfc0_addr = 5'd0;
    #1;
    checks++; if (Index_o !== 32'h8000_0000) begin errors++; $display("FAIL tlbp_miss_index got=%h exp=%h", Index_o, 32'h8000_0000); end
    checks++; if (mfc0_data !== 32'h8000_0000) begin errors++; $display("FAIL tlbp_miss_mfc0 got=%h exp=%h", mfc0_data, 32'h8000_0000); end
    tick;
    $display("tlbp Index_i=%h -> Index=%h", Index_i, Index_o);
  endtask

  task test_tlbr;
    EntryHi_i = 32'hFFFF_E0FF; PageMask_i = 32'hFFFF_FFFF;
    EntryLo0_i = 32'hFFFF_FFFF; EntryLo1_i = 32'h1234_5678;
    op = 3'd2; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    checks++; if (tlb_typeM !== 3'd2) begin errors++; $display("FAIL tlbr_typeM got=%0d exp=2", tlb_typeM); end
    tick;
    mfc0_addr = 5'd5;
    #1;
    checks++; if (EntryHi_o !== 32'hFFFF_E0FF) begin errors++; $display("FAIL tlbr_entryhi got=%h exp=%h", EntryHi_o, 32'hFFFF_E0FF); end
    checks++; if (PageMask_o !== 32'h1FFF_E000) begin errors++; $display("FAIL tlbr_pagemask got=%h exp=%h", PageMask_o, 32'h1FFF_E000); end
    checks++; if (EntryLo0_o !== 32'h3FFF_FFFF) begin errors++; $display("FAIL tlbr_entrylo0 got=%h exp=%h", EntryLo0_o, 32'h3FFF_FFFF); end
    checks++; if (EntryLo1_o !== 32'h1234_5678) begin errors++; $display("FAIL tlbr_entrylo1 got=%h exp=%h", EntryLo1_o, 32'h1234_5678); end
    checks++; if (mfc0_data !== 32'h1FFF_E000) begin errors++; $display("FAIL tlbr_mfc0_pagemask got=%h exp=%h", mfc0_data, 32'h1FFF_E000); end
    tick;
    $display("tlbr -> EntryHi=%h PageMask=%h", EntryHi_o, PageMask_o);
  endtask

  task test_mtc0_masks;
    do_mtc0(5'd0, 32'hFFFF_FFFF);
    checks++; if (Index_o !== 32'h8000_001F) begin errors++; $display("FAIL mask_index got=%h exp=%h", Index_o, 32'h8000_001F); end
    do_mtc0(5'd5, 32'h0000_0000);
    checks++; if (PageMask_o !== 32'h0) begin errors++; $display("FAIL mask_pagemask got=%h exp=%h", PageMask_o, 32'h0); end
    do_mtc0(5'd3, 32'hC000_0001);
    checks++; if (EntryLo1_o !== 32'h0000_0001) begin errors++; $display("FAIL mask_entrylo1 got=%h exp=%h", EntryLo1_o, 32'h1); end
    mfc0_addr = 5'd4; mfc0_sel = 3'd0;
    #1;
    checks++; if (mfc0_data !== 32'h0) begin errors++; $display("FAIL mfc0_unowned got=%h exp=%h", mfc0_data, 32'h0); end
    mfc0_addr = 5'd0; mfc0_sel = 3'd1;
    #1;
    checks++; if (mfc0_data !== 32'h0) begin errors++; $display("FAIL mfc0_sel1 got=%h exp=%h", mfc0_data, 32'h0); end
    mfc0_sel = 3'd0;
  endtask

  task test_exc;
    do_mtc0(5'd10, 32'h0000_0005);
    checks++; if (EntryHi_o !== 32'h0000_0005) begin errors++; $display("FAIL exc_prior_asid got=%h exp=%h", EntryHi_o, 32'h5); end
    mfc0_addr = 5'd10;
    mtc0_en = 1'b1; mtc0_addr = 5'd10; mtc0_sel = 3'd0; mtc0_data = 32'hAAAA_A0BB;
    exc_tlb = 1'b1; exc_vaddr = 32'h1234_5678;
    #1;
    checks++; if (mfc0_data !== 32'h0000_0005) begin errors++; $display("FAIL mfc0_no_bypass got=%h exp=%h", mfc0_data, 32'h5); end
    tick;
    mtc0_en = 1'b0; exc_tlb = 1'b0;
    checks++; if (EntryHi_o !== 32'h1234_4005) begin errors++; $display("FAIL exc_entryhi got=%h exp=%h", EntryHi_o, 32'h1234_4005); end
    $display("exc_tlb vaddr=%h -> EntryHi=%h", exc_vaddr, EntryHi_o);
    do_mtc0(5'd10, 32'hFFFF_FFFF);
    checks++; if (EntryHi_o !== 32'hFFFF_E0FF) begin errors++; $display("FAIL mask_entryhi got=%h exp=%h", EntryHi_o, 32'hFFFF_E0FF); end
  endtask

  task test_back_to_back;
    int n_done;
    int n_strobe;
    n_done = 0; n_strobe = 0;
    op = 3'd3; op_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (op_done === 1'b1) n_done++;
      if (tlb_typeM === 3'd3) n_strobe++;
    end
    op_valid = 1'b0;
    checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
    checks++; if (n_strobe !== 2) begin errors++; $display("FAIL b2b_strobe_count got=%0d exp=2", n_strobe); end
    tick;
    $display("back-to-back tlbwi: %0d strobes, %0d done pulses in 6 cycles", n_strobe, n_done);
  endtask

  task test_reset_mid;
    op = 3'd3; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    checks++; if (tlb_typeM !== 3'd3) begin errors++; $display("FAIL mid_typeM_issue got=%0d exp=3", tlb_typeM); end
    rst = 1'b1;
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", op_ready); end
    checks++; if (tlb_typeM !== 3'd0) begin errors++; $display("FAIL mid_typeM got=%0d exp=0", tlb_typeM); end
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", op_done); end
    checks++; if (EntryHi_o !== 32'h0) begin errors++; $display("FAIL mid_entryhi got=%h exp=%h", EntryHi_o, 32'h0); end
    tick;
    rst = 1'b0;
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL mid_done_after got=%b exp=0", op_done); end
    checks++; if (tlb_typeM !== 3'd0) begin errors++; $display("FAIL mid_typeM_after got=%0d exp=0", tlb_typeM); end
    tick;
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL mid_done_late got=%b exp=0", op_done); end
    $display("reset during tlbwi issue: returned to idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_random;
    test_tlbp;
    test_tlbr;
    test_mtc0_masks;
    test_exc;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
